// File: rtl/asconp_pkg.sv
// Shared types and constants for the Ascon permutation scheduler.
// Holds the default unroll factor, the legal round range, the round-count
// aliases used by the mode FSMs, the scheduler FSM state type and the
// 5 x 64-bit permutation state type (x0 occupies bits [63:0]).
package asconp_pkg;

    localparam int unsigned UROL     = 1;
    localparam int unsigned MAX_RND  = 12;

    localparam int unsigned ROUNDS_A = 12;
    localparam int unsigned ROUNDS_B = 8;
    localparam int unsigned ROUNDS_6 = 6;

    localparam int unsigned RND_W    = 4;
    localparam int unsigned WORD_W   = 64;
    localparam int unsigned NWORDS   = 5;
    localparam int unsigned STATE_W  = WORD_W * NWORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // Element [i] is word xi; element [0] sits in the low 64 bits.
    typedef logic [NWORDS-1:0][WORD_W-1:0] ascon_state_t;

endpackage

// File: rtl/asconp.sv
// Combinational Ascon permutation, UROL rounds per evaluation.
// Ports:
//   round_cnt  - rounds still to apply; first round uses constant index
//                ROUNDS_A - round_cnt
//   cur_state  - 320-bit input state (x0 = [63:0] ... x4 = [319:256])
//   next_state - state after UROL rounds, same mapping
module asconp
    import asconp_pkg::*;
#(
    parameter int unsigned UROL = asconp_pkg::UROL
) (
    input  logic [RND_W-1:0]   round_cnt,
    input  logic [STATE_W-1:0] cur_state,
    output logic [STATE_W-1:0] next_state
);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v,
                                               input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    // One full round: constant addition, bitsliced S-box, linear diffusion.
    function automatic ascon_state_t ascon_round(input ascon_state_t s,
                                                 input logic [RND_W-1:0] idx);
        ascon_state_t x;
        ascon_state_t t;
        x = s;
        x[2][7:0] = x[2][7:0] ^ {4'(4'd15 - idx), idx};

        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t[0] = ~x[0] & x[1];
        t[1] = ~x[1] & x[2];
        t[2] = ~x[2] & x[3];
        t[3] = ~x[3] & x[4];
        t[4] = ~x[4] & x[0];
        x[0] = x[0] ^ t[1];
        x[1] = x[1] ^ t[2];
        x[2] = x[2] ^ t[3];
        x[3] = x[3] ^ t[4];
        x[4] = x[4] ^ t[0];
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];

        x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return x;
    endfunction

    ascon_state_t rnd_state;

    // Chain UROL rounds; round k of this cycle uses constant index 12 - round_cnt + k.
    always_comb begin
        rnd_state = cur_state;
        for (int unsigned k = 0; k < UROL; k++) begin
            rnd_state = ascon_round(rnd_state,
                                    RND_W'(ROUNDS_A) - round_cnt + RND_W'(k));
        end
        next_state = rnd_state;
    end

endmodule

// File: rtl/asconp_sched.sv
// Sequencing controller for the Ascon permutation datapath.
// Accepts a state plus round count, iterates the permutation UROL rounds
// per clock and returns the result over a valid/ready handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  - request handshake (ready only in IDLE)
//   nrounds_i, state_i       - rounds to apply and input state
//   out_valid_o/out_ready_i  - result handshake (valid only in DONE)
//   state_o                  - state register contents
//   err_o                    - result belongs to an illegal request
//   busy_o                   - high in RUN or DONE
//   abort_i                  - present only with ASCONP_SCHED_ABORT_EN defined
module asconp_sched
    import asconp_pkg::*;
#(
    parameter int unsigned UROL    = asconp_pkg::UROL,
    parameter int unsigned MAX_RND = asconp_pkg::MAX_RND
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [RND_W-1:0]   nrounds_i,
    input  logic [STATE_W-1:0] state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [STATE_W-1:0] state_o,
    output logic               err_o,
    output logic               busy_o
`ifdef ASCONP_SCHED_ABORT_EN
    ,
    input  logic               abort_i
`endif
);

    sched_state_e     fsm_q, fsm_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    ascon_state_t     st_q, st_d;
    logic [STATE_W-1:0] perm_out;
    logic             err_q, err_d;
    logic             rdy_q, rdy_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             illegal_c;
    logic             abort_c;

`ifdef ASCONP_SCHED_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    // Round counts must fit the schedule exactly so rnd_q lands on UROL.
    assign illegal_c = (32'(nrounds_i) > MAX_RND) || ((32'(nrounds_i) % UROL) != 0);

    asconp #(.UROL(UROL)) u_asconp (
        .round_cnt  (rnd_q),
        .cur_state  (st_q),
        .next_state (perm_out)
    );

    // Next-state and next-output decode.
    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        st_d  = st_q;
        err_d = err_q;

        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    st_d  = state_i;
                    rnd_d = nrounds_i;
                    if (illegal_c) begin
                        fsm_d = ST_DONE;
                        err_d = 1'b1;
                    end else if (nrounds_i == '0) begin
                        fsm_d = ST_DONE;
                        err_d = 1'b0;
                    end else begin
                        fsm_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                st_d  = perm_out;
                rnd_d = rnd_q - RND_W'(UROL);
                if (rnd_q == RND_W'(UROL)) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    fsm_d = ST_IDLE;
                    err_d = 1'b0;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        // Abort wins over both a RUN update and a DONE handshake.
        if (abort_c && (fsm_q != ST_IDLE)) begin
            fsm_d = ST_IDLE;
            st_d  = st_q;
            rnd_d = '0;
            err_d = 1'b0;
        end

        rdy_d  = (fsm_d == ST_IDLE);
        vld_d  = (fsm_d == ST_DONE);
        busy_d = (fsm_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            rnd_q  <= '0;
            st_q   <= '0;
            err_q  <= 1'b0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            st_q   <= st_d;
            err_q  <= err_d;
            rdy_q  <= rdy_d;
            vld_q  <= vld_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign state_o     = st_q;

endmodule

// File: tb/tb_asconp_sched.sv
// Directed bench for asconp_sched: three instances with UROL = 1, 2, 3,
// checked against a table-driven Ascon permutation model.
`timescale 1ns/1ps
module tb_asconp_sched;

    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [3:0]   nrounds   [NDUT];
    logic [319:0] st_in     [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [319:0] st_out    [NDUT];
    logic         err       [NDUT];
    logic         busy      [NDUT];
`ifdef ASCONP_SCHED_ABORT_EN
    logic         abort     [NDUT];
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        asconp_sched #(.UROL(g + 1), .MAX_RND(12)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .nrounds_i   (nrounds[g]),
            .state_i     (st_in[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .state_o     (st_out[g]),
            .err_o       (err[g]),
            .busy_o      (busy[g])
`ifdef ASCONP_SCHED_ABORT_EN
            ,
            .abort_i     (abort[g])
`endif
        );
    end

    // Ascon 5-bit S-box, index bit 4 = x0 ... bit 0 = x4.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int nr);
        logic [63:0]  w [5];
        logic [63:0]  y [5];
        logic [4:0]   col;
        logic [4:0]   o;
        logic [319:0] res;
        for (int i = 0; i < 5; i++) w[i] = s_in[64*i +: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            w[2] = w[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
                o = SBOX[col];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            w[0] = y[0] ^ ror64(y[0], 19) ^ ror64(y[0], 28);
            w[1] = y[1] ^ ror64(y[1], 61) ^ ror64(y[1], 39);
            w[2] = y[2] ^ ror64(y[2], 1)  ^ ror64(y[2], 6);
            w[3] = y[3] ^ ror64(y[3], 10) ^ ror64(y[3], 17);
            w[4] = y[4] ^ ror64(y[4], 7)  ^ ror64(y[4], 41);
        end
        for (int i = 0; i < 5; i++) res[64*i +: 64] = w[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance d, measure latency (accept edge = 1),
    // check the result, then consume it.
    task automatic run_job(input int d, input int nr, input logic [319:0] s,
                           input int exp_lat, input logic exp_err,
                           input logic [319:0] exp_s, input logic early_rdy,
                           input string tag);
        int lat;
        check({tag, " ready before"}, 320'(in_ready[d]), 320'(1));
        in_valid[d]  = 1'b1;
        nrounds[d]   = 4'(nr);
        st_in[d]     = s;
        out_ready[d] = early_rdy;
        tick();
        in_valid[d] = 1'b0;
        lat = 1;
        while (!out_valid[d] && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 320'(lat), 320'(exp_lat));
        check({tag, " err"}, 320'(err[d]), 320'(exp_err));
        check({tag, " state"}, st_out[d], exp_s);
        check({tag, " busy"}, 320'(busy[d]), 320'(1));
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check({tag, " ready after"}, 320'(in_ready[d]), 320'(1));
        check({tag, " valid after"}, 320'(out_valid[d]), 320'(0));
    endtask

    logic [319:0] s0, s1, s2, s3, exp_r;
    int           lat;

    initial begin
        s0 = '0;
        s1 = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;
        s2 = 320'h80400c0600000000_a5a5a5a55a5a5a5a_0000000000000001_ffffffffffffffff_1357924680aceb0d;
        s3 = 320'h00400c0000000100_b57e273b814cd416_2b51042562ae2420_66a3a7768ddf2218_5aad0a7a8153650c;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            nrounds[i]   = '0;
            st_in[i]     = '0;
            out_ready[i] = 1'b0;
`ifdef ASCONP_SCHED_ABORT_EN
            abort[i]     = 1'b0;
`endif
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset ready %0d", i), 320'(in_ready[i]), 320'(1));
            check($sformatf("reset valid %0d", i), 320'(out_valid[i]), 320'(0));
            check($sformatf("reset err %0d", i), 320'(err[i]), 320'(0));
            check($sformatf("reset busy %0d", i), 320'(busy[i]), 320'(0));
            check($sformatf("reset state %0d", i), st_out[i], 320'(0));
        end

        run_job(0, 12, s0, 13, 1'b0, model_perm(s0, 12), 1'b0, "p12 u1 zero");
        run_job(1, 12, s1, 7,  1'b0, model_perm(s1, 12), 1'b0, "p12 u2");
        run_job(1, 8,  s2, 5,  1'b0, model_perm(s2, 8),  1'b0, "p8 u2");
        run_job(2, 6,  s3, 3,  1'b0, model_perm(s3, 6),  1'b1, "p6 u3 early rdy");
        run_job(0, 6,  s1, 7,  1'b0, model_perm(s1, 6),  1'b1, "p6 u1 early rdy");
        run_job(1, 7,  s3, 1,  1'b1, s3, 1'b0, "n7 u2 illegal");
        run_job(0, 13, s2, 1,  1'b1, s2, 1'b0, "n13 u1 illegal");
        run_job(0, 0,  s1, 1,  1'b0, s1, 1'b0, "n0 u1");

        // Backpressure: result must hold while a new request waits upstream.
        in_valid[0] = 1'b1;
        nrounds[0]  = 4'd8;
        st_in[0]    = s2;
        tick();
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 100) begin
            tick();
            lat++;
        end
        check("bp latency", 320'(lat), 320'(9));
        exp_r       = model_perm(s2, 8);
        in_valid[0] = 1'b1;
        nrounds[0]  = 4'd12;
        st_in[0]    = s3;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp valid", 320'(out_valid[0]), 320'(1));
            check("bp state", st_out[0], exp_r);
            check("bp ready", 320'(in_ready[0]), 320'(0));
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("bp ready after hs", 320'(in_ready[0]), 320'(1));
        check("bp valid after hs", 320'(out_valid[0]), 320'(0));
        check("bp busy after hs", 320'(busy[0]), 320'(0));
        check("bp no accept at hs", st_out[0], exp_r);
        in_valid[0] = 1'b0;
        tick();

        // Reset in the 4th RUN cycle.
        in_valid[0] = 1'b1;
        nrounds[0]  = 4'd12;
        st_in[0]    = s1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        check("mid run busy", 320'(busy[0]), 320'(1));
        rst = 1'b1;
        tick();
        check("rst ready", 320'(in_ready[0]), 320'(1));
        check("rst valid", 320'(out_valid[0]), 320'(0));
        check("rst busy", 320'(busy[0]), 320'(0));
        check("rst state", st_out[0], 320'(0));
        rst = 1'b0;
        tick();
        run_job(0, 12, s3, 13, 1'b0, model_perm(s3, 12), 1'b0, "p12 after rst");

`ifdef ASCONP_SCHED_ABORT_EN
        // Abort in RUN cycle 2, then a back-to-back p12.
        in_valid[0] = 1'b1;
        nrounds[0]  = 4'd12;
        st_in[0]    = s1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("abort ready", 320'(in_ready[0]), 320'(1));
        check("abort valid", 320'(out_valid[0]), 320'(0));
        check("abort busy", 320'(busy[0]), 320'(0));
        run_job(0, 12, s2, 13, 1'b0, model_perm(s2, 12), 1'b0, "p12 after abort");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
